// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and instruction register,
// fetches over req/gnt/rvalid and applies ctrl's pc/inst selects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_sel,
    input  logic [1:0]  inst_sel,
    input  logic [31:0] alu_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_p4,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic        inst_valid,
    output logic        fetch_err,
    output logic        misalign
);

    localparam logic [1:0] PC_P4    = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_OLD   = 2'd2;
    localparam logic [1:0] PC_M4    = 2'd3;

    localparam logic [1:0] INST_MEM = 2'd0;
    localparam logic [1:0] INST_NOP = 2'd1;
    localparam logic [1:0] INST_OLD = 2'd2;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] nxt;
    logic        unused_ok;

    assign unused_ok = alu_out[0];

    // Next PC as chosen by ctrl; only committed in EXEC
    always_comb begin
        nxt = pc;
        unique case (pc_sel)
            PC_P4:   nxt = pc + 32'd4;
            PC_ALU:  nxt = {alu_out[31:2], 2'b00};
            PC_OLD:  nxt = pc;
            PC_M4:   nxt = pc - 32'd4;
            default: nxt = pc;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; request is masked while reset is held
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        unique case (state)
            REQ: begin
                imem_req = rst;
                if (imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (inst_sel == INST_NOP || inst_sel == INST_OLD) begin
                    state_nxt = EXEC;
                end else begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    // PC, instruction register, sticky error and misalign pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            inst      <= NOP_INST;
            fetch_err <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (state == WAIT && imem_rvalid) begin
                if (imem_err) begin
                    inst      <= NOP_INST;
                    fetch_err <= 1'b1;
                end else begin
                    inst <= imem_rdata;
                end
            end
            if (state == EXEC) begin
                pc       <= nxt;
                misalign <= (pc_sel == PC_ALU) && alu_out[1];
                if (inst_sel == INST_NOP) begin
                    inst <= NOP_INST;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign pc_p4     = pc + 32'd4;
    assign opcode    = inst[6:2];
    assign func3     = inst[14:12];
    assign func7     = inst[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed sequences push expected
// fetch addresses and executed (pc, inst) pairs; a monitor compares.
module tb_fetch_unit;

    localparam logic [1:0] PC_P4    = 2'd0;
    localparam logic [1:0] PC_ALU   = 2'd1;
    localparam logic [1:0] PC_OLD   = 2'd2;
    localparam logic [1:0] PC_M4    = 2'd3;
    localparam logic [1:0] INST_MEM = 2'd0;
    localparam logic [1:0] INST_NOP = 2'd1;
    localparam logic [1:0] INST_OLD = 2'd2;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pc_sel = '0;
    logic [1:0]  inst_sel = '0;
    logic [31:0] alu_out = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        inst_valid;
    logic        fetch_err;
    logic        misalign;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .pc_sel(pc_sel), .inst_sel(inst_sel), .alu_out(alu_out),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .inst(inst), .pc(pc), .pc_p4(pc_p4),
        .opcode(opcode), .func3(func3), .func7(func7),
        .inst_valid(inst_valid), .fetch_err(fetch_err),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exec_t;

    exec_t       exec_q[$];
    logic [31:0] req_q[$];
    exec_t       mon_e;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: compare on request start, request hold and each executed cycle
    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
        end else begin
            if (imem_req) begin
                if (!prev_req) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req got addr %h want none", imem_addr);
                    end else begin
                        chk("req_addr", imem_addr, req_q.pop_front());
                    end
                end else begin
                    chk("addr_stable", imem_addr, prev_addr);
                end
            end
            if (inst_valid) begin
                if (exec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid got pc %h want none", pc);
                end else begin
                    mon_e = exec_q.pop_front();
                    chk("exec_pc", pc, mon_e.pc);
                    chk("exec_inst", inst, mon_e.inst);
                    chk("exec_pc_p4", pc_p4, mon_e.pc + 32'd4);
                    chk("exec_opcode", {27'd0, opcode}, {27'd0, mon_e.inst[6:2]});
                    chk("exec_func3", {29'd0, func3}, {29'd0, mon_e.inst[14:12]});
                    chk("exec_func7", {25'd0, func7}, {25'd0, mon_e.inst[31:25]});
                end
            end
            prev_req  = imem_req;
            prev_addr = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one fetch from REQ: gnt after dly cycles, rvalid the cycle after
    task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                         input logic e, input int dly, input bit push_req);
        if (push_req) req_q.push_back(a);
        exec_q.push_back('{a, e ? NOP : d});
        imem_gnt = 1'b0;
        repeat (dly) tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        imem_err    = e;
        tick();
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = '0;
    endtask

    // Drive one EXEC cycle; stay-in-EXEC cases expect another executed pair
    task automatic run_exec(input logic [1:0] ps, input logic [1:0] is,
                            input logic [31:0] alu, input logic [31:0] epc,
                            input logic [31:0] einst);
        pc_sel   = ps;
        inst_sel = is;
        alu_out  = alu;
        if (is != INST_MEM) exec_q.push_back('{epc, einst});
        tick();
        pc_sel   = '0;
        inst_sel = '0;
        alu_out  = '0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_inst", inst, NOP);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);

        rst = 1'b1;
        #1;
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        fetch(32'h0, 32'h0050_0093, 1'b0, 0, 1'b1);
        chk("t1_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_opcode", {27'd0, opcode}, 32'h4);

        run_exec(PC_ALU, INST_MEM, 32'h10, 32'h0, 32'h0);
        fetch(32'h10, 32'h4000_0033, 1'b0, 0, 1'b1);
        chk("t2_func7", {25'd0, func7}, 32'h20);
        run_exec(PC_ALU, INST_NOP, 32'h102, 32'h100, NOP);
        chk("t2_misalign", {31'd0, misalign}, 32'd1);
        chk("t2_inst", inst, NOP);
        chk("t2_pc", pc, 32'h100);
        run_exec(PC_OLD, INST_MEM, 32'h0, 32'h0, 32'h0);
        chk("t2_misalign_pulse", {31'd0, misalign}, 32'd0);
        fetch(32'h100, 32'h0010_0113, 1'b0, 0, 1'b1);

        run_exec(PC_ALU, INST_MEM, 32'h20, 32'h0, 32'h0);
        chk("t3_no_misalign", {31'd0, misalign}, 32'd0);
        fetch(32'h20, 32'h0000_A103, 1'b0, 0, 1'b1);
        run_exec(PC_M4, INST_OLD, 32'h0, 32'h1C, 32'h0000_A103);
        run_exec(PC_P4, INST_NOP, 32'h0, 32'h20, NOP);
        chk("t3_pc", pc, 32'h20);

        run_exec(PC_P4, INST_MEM, 32'h0, 32'h0, 32'h0);
        fetch(32'h24, 32'h0020_8233, 1'b0, 5, 1'b1);

        run_exec(PC_P4, INST_MEM, 32'h0, 32'h0, 32'h0);
        fetch(32'h28, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
        chk("t5_err", {31'd0, fetch_err}, 32'd1);
        chk("t5_inst", inst, NOP);
        run_exec(PC_ALU, INST_MEM, 32'hFFFF_FFFC, 32'h0, 32'h0);
        chk("t5_err_sticky", {31'd0, fetch_err}, 32'd1);
        fetch(32'hFFFF_FFFC, 32'h0010_0073, 1'b0, 0, 1'b1);
        chk("wrap_pc_p4", pc_p4, 32'h0);
        run_exec(PC_P4, INST_OLD, 32'h0, 32'h0, 32'h0010_0073);
        chk("wrap_up_pc", pc, 32'h0);
        run_exec(PC_M4, INST_OLD, 32'h0, 32'hFFFF_FFFC, 32'h0010_0073);
        chk("t5_err_held", {31'd0, fetch_err}, 32'd1);

        req_q.push_back(32'h0);
        run_exec(PC_P4, INST_MEM, 32'h0, 32'h0, 32'h0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t6_rst_err", {31'd0, fetch_err}, 32'd0);
        chk("t6_rst_pc", pc, 32'h0);
        chk("t6_rst_inst", inst, NOP);
        tick();
        tick();
        rst = 1'b1;
        req_q.push_back(32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("t6_still_req", {31'd0, imem_req}, 32'd1);
        chk("t6_ignored", inst, NOP);
        fetch(32'h0, 32'h00C0_0093, 1'b0, 0, 1'b0);
        run_exec(PC_P4, INST_NOP, 32'h0, 32'h4, NOP);
        req_q.push_back(32'h8);
        run_exec(PC_P4, INST_MEM, 32'h0, 32'h0, 32'h0);
        repeat (3) tick();

        chk("exec_q_empty", exec_q.size(), 32'd0);
        chk("req_q_empty", req_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
